// File: rtl/ram_arb_pkg.sv
// Shared types and default parameter values for the RAM port-B arbiter.
package ram_arb_pkg;

    localparam int ADDR_W_DEF        = 11;
    localparam int DATA_W_DEF        = 32;
    localparam int CLEAR_WORDS_DEF   = 100;
    localparam int VGA_BURST_MAX_DEF = 8;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_VGA,
        GNT_UART,
        GNT_CLR
    } grant_e;

endpackage

// File: rtl/ram_clear_engine.sv
// Clear engine: walks word addresses 0..CLEAR_WORDS-1, advancing one word per granted write.
//
// state    | meaning
// CLR_IDLE | waiting for start; start here loads address 0
// CLR_RUN  | busy; each grant writes addr_q and advances, last word returns to idle
module ram_clear_engine
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int CLEAR_WORDS = CLEAR_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              grant,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr
);

    typedef enum logic {
        CLR_IDLE,
        CLR_RUN
    } clr_state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLEAR_WORDS - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLR_IDLE;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (start) begin
                    state_d = CLR_RUN;
                    addr_d  = '0;
                end
            end
            CLR_RUN: begin
                // start is ignored while running
                if (grant) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = CLR_IDLE;
                        addr_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = CLR_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    assign busy = (state_q == CLR_RUN);
    assign done = done_q;
    assign addr = addr_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates RAM port B between VGA reads, UART loader writes and the board clear engine.
// Define RAM_CLEAR_EN to build in the clear engine; otherwise only VGA/UART are arbitrated.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int CLEAR_WORDS   = CLEAR_WORDS_DEF,
    parameter int VGA_BURST_MAX = VGA_BURST_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_data,
    input  logic              uart_req,
    input  logic [ADDR_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_wdata,
    output logic              uart_ack,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [DATA_W-1:0] ram_data_b,
    output logic              ram_wren_b,
    input  logic [DATA_W-1:0] ram_q_b
);

    localparam int             BURST_W   = $clog2(VGA_BURST_MAX + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(VGA_BURST_MAX);

    grant_e             grant;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               prefer_clr_q, prefer_clr_d;
    logic               vga_valid_q, vga_valid_d;
    logic               clr_pending;
    logic [ADDR_W-1:0]  clr_addr;

`ifdef RAM_CLEAR_EN
    ram_clear_engine #(
        .ADDR_W      (ADDR_W),
        .CLEAR_WORDS (CLEAR_WORDS)
    ) u_clear (
        .clk   (clk),
        .rst   (rst),
        .start (clr_start),
        .grant (grant == GNT_CLR),
        .busy  (clr_pending),
        .done  (clr_done),
        .addr  (clr_addr)
    );
`else
    logic unused_clr_start;
    assign unused_clr_start = clr_start;
    assign clr_pending      = 1'b0;
    assign clr_done         = 1'b0;
    assign clr_addr         = '0;
`endif

    assign clr_busy = clr_pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_q      <= '0;
            prefer_clr_q <= 1'b0;
            vga_valid_q  <= 1'b0;
        end else begin
            burst_q      <= burst_d;
            prefer_clr_q <= prefer_clr_d;
            vga_valid_q  <= vga_valid_d;
        end
    end

    // Grant is forced to none while in reset so the combinational port-B outputs read 0.
    always_comb begin
        grant = GNT_NONE;
        if (rst) begin
            if (vga_req && !((burst_q == BURST_MAX) && (uart_req || clr_pending))) begin
                grant = GNT_VGA;
            end else if (uart_req && clr_pending) begin
                grant = prefer_clr_q ? GNT_CLR : GNT_UART;
            end else if (uart_req) begin
                grant = GNT_UART;
            end else if (clr_pending) begin
                grant = GNT_CLR;
            end
        end
    end

    always_comb begin
        burst_d      = '0;
        prefer_clr_d = prefer_clr_q;
        vga_valid_d  = 1'b0;
        ram_wren_b   = 1'b0;
        ram_addr_b   = '0;
        ram_data_b   = '0;
        uart_ack     = 1'b0;
        case (grant)
            GNT_VGA: begin
                burst_d     = (burst_q == BURST_MAX) ? burst_q : burst_q + 1'b1;
                vga_valid_d = 1'b1;
                ram_addr_b  = vga_addr;
            end
            GNT_UART: begin
                prefer_clr_d = 1'b1;
                ram_wren_b   = 1'b1;
                ram_addr_b   = uart_addr;
                ram_data_b   = uart_wdata;
                uart_ack     = 1'b1;
            end
            GNT_CLR: begin
                prefer_clr_d = 1'b0;
                ram_wren_b   = 1'b1;
                ram_addr_b   = clr_addr;
            end
            default: ;
        endcase
    end

    assign vga_valid = vga_valid_q;
    assign vga_data  = vga_valid_q ? ram_q_b : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural registered RAM on port B.
module tb_ram_port_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_valid;
    logic [DATA_W-1:0] vga_data;
    logic              uart_req;
    logic [ADDR_W-1:0] uart_addr;
    logic [DATA_W-1:0] uart_wdata;
    logic              uart_ack;
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    logic [ADDR_W-1:0] ram_addr_b;
    logic [DATA_W-1:0] ram_data_b;
    logic              ram_wren_b;
    logic [DATA_W-1:0] ram_q_b;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_valid  (vga_valid),
        .vga_data   (vga_data),
        .uart_req   (uart_req),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_ack   (uart_ack),
        .clr_start  (clr_start),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .ram_addr_b (ram_addr_b),
        .ram_data_b (ram_data_b),
        .ram_wren_b (ram_wren_b),
        .ram_q_b    (ram_q_b)
    );

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h1111_1111;
        mem[5] = 32'h0000_00A5;
        ram_q_b = '0;
    end

    always @(posedge clk) begin
        if (ram_wren_b) mem[ram_addr_b] <= ram_data_b;
        ram_q_b <= mem[ram_addr_b];
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        vga_req    = 1'b0;
        vga_addr   = '0;
        uart_req   = 1'b0;
        uart_addr  = '0;
        uart_wdata = '0;
        clr_start  = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        vga_req  = 1'b1;
        uart_req = 1'b1;
        #2;
        chk_eq("rst_vga_valid", 32'(vga_valid), 32'd0);
        chk_eq("rst_vga_data", vga_data, 32'd0);
        chk_eq("rst_uart_ack", 32'(uart_ack), 32'd0);
        chk_eq("rst_clr_busy", 32'(clr_busy), 32'd0);
        chk_eq("rst_clr_done", 32'(clr_done), 32'd0);
        chk_eq("rst_wren", 32'(ram_wren_b), 32'd0);
        chk_eq("rst_addr", 32'(ram_addr_b), 32'd0);
        chk_eq("rst_data", ram_data_b, 32'd0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);

        // single VGA read of word 5
        vga_req  = 1'b1;
        vga_addr = 11'd5;
        #1;
        chk_eq("vga_wren", 32'(ram_wren_b), 32'd0);
        chk_eq("vga_addr", 32'(ram_addr_b), 32'd5);
        @(negedge clk);
        vga_req = 1'b0;
        #1;
        chk_eq("vga_valid", 32'(vga_valid), 32'd1);
        chk_eq("vga_data", vga_data, 32'h0000_00A5);
        chk_eq("idle_addr", 32'(ram_addr_b), 32'd0);
        @(negedge clk);
        #1;
        chk_eq("vga_valid_drop", 32'(vga_valid), 32'd0);

        // single UART write
        @(negedge clk);
        uart_req   = 1'b1;
        uart_addr  = 11'h010;
        uart_wdata = 32'h7;
        #1;
        chk_eq("uart_ack", 32'(uart_ack), 32'd1);
        chk_eq("uart_wren", 32'(ram_wren_b), 32'd1);
        chk_eq("uart_addr", 32'(ram_addr_b), 32'h10);
        chk_eq("uart_data", ram_data_b, 32'h7);
        @(negedge clk);
        uart_req = 1'b0;
        #1;
        chk_eq("uart_mem", mem[16], 32'h7);
        chk_eq("uart_ack_drop", 32'(uart_ack), 32'd0);

        // VGA held with UART pending: 8 VGA grants then 1 UART, repeating
        @(negedge clk);
        vga_req    = 1'b1;
        vga_addr   = 11'd5;
        uart_req   = 1'b1;
        uart_addr  = 11'h020;
        uart_wdata = 32'h55;
        for (int i = 0; i < 27; i++) begin
            #1;
            chk_eq($sformatf("burst_ack_%0d", i), 32'(uart_ack), (i % 9 == 8) ? 32'd1 : 32'd0);
            chk_eq($sformatf("burst_wren_%0d", i), 32'(ram_wren_b), (i % 9 == 8) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        uart_req = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        // burst counter saturated: a newly pending UART wins immediately
        uart_req = 1'b1;
        #1;
        chk_eq("sat_ack", 32'(uart_ack), 32'd1);
        @(negedge clk);
        #1;
        chk_eq("sat_vga_again", 32'(uart_ack), 32'd0);
        chk_eq("sat_vga_addr", 32'(ram_addr_b), 32'd5);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);

`ifdef RAM_CLEAR_EN
        // clear with no other traffic
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        #1;
        chk_eq("clr_busy_set", 32'(clr_busy), 32'd1);
        for (int i = 0; i < 100; i++) begin
            if (i == 50) clr_start = 1'b1;
            #1;
            chk_eq($sformatf("clr_wren_%0d", i), 32'(ram_wren_b), 32'd1);
            chk_eq($sformatf("clr_addr_%0d", i), 32'(ram_addr_b), 32'(i));
            chk_eq($sformatf("clr_data_%0d", i), ram_data_b, 32'd0);
            chk_eq($sformatf("clr_done_early_%0d", i), 32'(clr_done), 32'd0);
            @(negedge clk);
            clr_start = 1'b0;
        end
        #1;
        chk_eq("clr_done_pulse", 32'(clr_done), 32'd1);
        chk_eq("clr_busy_fall", 32'(clr_busy), 32'd0);
        chk_eq("clr_idle_wren", 32'(ram_wren_b), 32'd0);
        chk_eq("clr_mem99", mem[99], 32'd0);
        chk_eq("clr_mem100", mem[100], 32'h1111_1111);
        @(negedge clk);
        #1;
        chk_eq("clr_done_once", 32'(clr_done), 32'd0);

        // reset at clear address 40
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        begin
            int guard = 0;
            while (ram_addr_b != 11'd40 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            chk_eq("rst40_reached", 32'(ram_addr_b), 32'd40);
        end
        rst = 1'b0;
        #1;
        chk_eq("rst40_wren", 32'(ram_wren_b), 32'd0);
        chk_eq("rst40_addr", 32'(ram_addr_b), 32'd0);
        chk_eq("rst40_busy", 32'(clr_busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_eq($sformatf("rst40_no_done_%0d", i), 32'(clr_done), 32'd0);
            chk_eq($sformatf("rst40_no_wr_%0d", i), 32'(ram_wren_b), 32'd0);
            @(negedge clk);
        end

        // restarted clear contending with UART: UART first after reset, then alternate
        clr_start = 1'b1;
        @(negedge clk);
        clr_start  = 1'b0;
        uart_req   = 1'b1;
        uart_addr  = 11'h200;
        uart_wdata = 32'hBEEF;
        begin
            bit exp_uart = 1'b1;
            int clr_cnt  = 0;
            int guard    = 0;
            while (clr_cnt < 100 && guard < 300) begin
                #1;
                if (exp_uart) begin
                    chk_eq($sformatf("alt_ack_%0d", guard), 32'(uart_ack), 32'd1);
                end else begin
                    chk_eq($sformatf("alt_noack_%0d", guard), 32'(uart_ack), 32'd0);
                    chk_eq($sformatf("alt_clr_addr_%0d", guard), 32'(ram_addr_b), 32'(clr_cnt));
                    clr_cnt++;
                end
                exp_uart = !exp_uart;
                guard++;
                @(negedge clk);
            end
            chk_eq("alt_clr_count", 32'(clr_cnt), 32'd100);
        end
        #1;
        chk_eq("alt_done", 32'(clr_done), 32'd1);
        chk_eq("alt_busy", 32'(clr_busy), 32'd0);
        idle_inputs();
        @(negedge clk);
`else
        // clear engine not built: clr_start has no effect
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_eq($sformatf("noclr_busy_%0d", i), 32'(clr_busy), 32'd0);
            chk_eq($sformatf("noclr_done_%0d", i), 32'(clr_done), 32'd0);
            chk_eq($sformatf("noclr_wren_%0d", i), 32'(ram_wren_b), 32'd0);
            @(negedge clk);
        end
        chk_eq("noclr_mem0", mem[0], 32'h1111_1111);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, RAM word width.
REQ-003 SHALL have parameter CLEAR_WORDS, default 100, words zeroed by clear engine (10x10 board region at word 0).
REQ-004 SHALL have parameter VGA_BURST_MAX, default 8, max consecutive VGA grants while others wait.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 vga_req  in  1  display read request.
REQ-008 vga_addr  in  ADDR_W  display read address.
REQ-009 vga_valid  out  1  vga_data valid.
REQ-010 vga_data  out  DATA_W  read word.
REQ-011 uart_req  in  1  loader write request, held until ack.
REQ-012 uart_addr  in  ADDR_W  loader write address.
REQ-013 uart_wdata  in  DATA_W  loader write data.
REQ-014 uart_ack  out  1  one-cycle pulse, write issued this cycle.
REQ-015 clr_start  in  1  pulse, begin clear.
REQ-016 clr_busy  out  1  clear in progress.
REQ-017 clr_done  out  1  one-cycle pulse after last clear write.
REQ-018 ram_addr_b  out  ADDR_W  RAM port-B address.
REQ-019 ram_data_b  out  DATA_W  RAM port-B write data.
REQ-020 ram_wren_b  out  1  RAM port-B write enable.
REQ-021 ram_q_b  in  DATA_W  RAM port-B read data, registered, 1-cycle latency.

Function
REQ-022 Grant SHALL be decided combinationally each cycle among VGA, UART, CLR; port-B outputs driven from the winner in the same cycle.
REQ-023 VGA SHALL win whenever vga_req=1, unless the VGA burst counter equals VGA_BURST_MAX and UART or CLR is pending; then the non-VGA winner takes the cycle and the counter clears.
REQ-024 Burst counter SHALL increment on each VGA grant (saturating at VGA_BURST_MAX) and clear on any non-VGA grant or idle cycle.
REQ-025 UART vs CLR contention SHALL be round-robin: last-served flag alternates; after reset UART has priority.
REQ-026 VGA grant: ram_wren_b=0, ram_addr_b=vga_addr; next cycle vga_valid=1 and vga_data=ram_q_b.
REQ-027 UART grant: ram_wren_b=1, addr/data from uart_*, uart_ack=1 same cycle; uart_req dropped before grant SHALL cause no write.
REQ-028 CLR grant: ram_wren_b=1, ram_addr_b=clear counter, ram_data_b=0; counter increments.
REQ-029 clr_start SHALL set clr_busy next cycle and counter=0; clr_start while busy SHALL be ignored.
REQ-030 On the grant writing address CLEAR_WORDS-1, clr_busy SHALL fall and clr_done pulse the following cycle.
REQ-031 No grant: ram_wren_b=0, ram_addr_b=0, ram_data_b=0, vga_valid=0 next cycle.
REQ-032 At most one write SHALL issue per cycle; vga_valid SHALL never assert without a prior-cycle VGA grant.

Reset
REQ-033 On rst=0, all outputs SHALL be 0 asynchronously: vga_valid, vga_data, uart_ack, clr_busy, clr_done, ram_wren_b, ram_addr_b, ram_data_b.
REQ-034 Reset mid-clear SHALL abort: counter=0, clr_busy=0, no clr_done; round-robin flag to UART, burst counter 0.

Configuration
REQ-035 Macro RAM_CLEAR_EN SHALL compile in the clear engine; without it clr_start is ignored, clr_busy and clr_done tie to 0, arbitration reduces to VGA/UART with burst limit.

Structure
REQ-036 Shared package ram_arb_pkg SHALL hold grant enum (GNT_NONE, GNT_VGA, GNT_UART, GNT_CLR) and default-parameter constants.
REQ-037 Clear engine SHALL be sub-module ram_clear_engine (start, grant in; busy, done, addr out).

Verification
REQ-038 Only vga_req, vga_addr=5, ram model word5=0xA5 -> next cycle vga_valid=1, vga_data=0x000000A5.
REQ-039 uart_req, addr=0x10, wdata=0x7 with vga_req idle -> same-cycle uart_ack=1, ram_wren_b=1, RAM word 0x10=0x7.
REQ-040 vga_req held continuously plus uart_req -> 8 VGA grants, 1 UART grant (ack), repeat pattern.
REQ-041 clr_start with no other traffic -> 100 writes of 0 to addrs 0..99, clr_done pulse one cycle after addr 99, clr_busy low.
REQ-042 UART and CLR both pending, VGA idle -> grants alternate UART, CLR, UART...; clear takes 100 CLR grants.
REQ-043 rst asserted at clear address 40 -> outputs 0 immediately, no clr_done; new clr_start restarts at addr 0.
